// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and default capacity.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  localparam int DEPTH_DEF = 1024;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words into imem and holds the CPU until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [15:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t        state, state_nxt;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_inc;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [7:0]    hi_byte;
  logic [15:0]   n_word;
  logic          xfer;
  logic          start_ok;
  logic          last_word;
`ifdef LOADER_CSUM_EN
  logic [7:0]    csum;
`endif

  assign in_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CSUM);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign n_word    = {len_hi, in_byte};
  assign cnt_inc   = cnt + {{AW{1'b0}}, 1'b1};
  assign last_word = (cnt_inc == {{(AW+1-16){1'b0}}, len});

  assign cpu_hold  = (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start_ok) state_nxt = LEN_HI;
      LEN_HI:          if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (n_word == 16'd0) begin
`ifdef LOADER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else if ({1'b0, n_word} > DEPTH_W) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI:         if (xfer) state_nxt = DATA_LO;
      DATA_LO: begin
        if (xfer) begin
          if (last_word) begin
`ifdef LOADER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
`ifdef LOADER_CSUM_EN
      CSUM:            if (xfer) state_nxt = (in_byte == csum) ? DONE : ERR;
`endif
      default:         state_nxt = IDLE;
    endcase
  end

  // Control state and the registered imem write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (start_ok) cnt <= '0;
      if ((state == DATA_LO) && xfer) begin
        imem_we    <= 1'b1;
        imem_waddr <= cnt[AW-1:0];
        imem_wdata <= {hi_byte, in_byte};
        cnt        <= cnt_inc;
      end
    end
  end

  // Stream capture registers; every use is preceded by a fresh write in the same load
  always_ff @(posedge clk) begin
    if ((state == LEN_HI) && xfer) len_hi <= in_byte;
    if ((state == LEN_LO) && xfer) len <= n_word;
    if ((state == DATA_HI) && xfer) hi_byte <= in_byte;
`ifdef LOADER_CSUM_EN
    if (start_ok) csum <= 8'h00;
    else if (((state == DATA_HI) || (state == DATA_LO)) && xfer) csum <= csum ^ in_byte;
`endif
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; covers both builds with and without LOADER_CSUM_EN.
module tb_imem_loader;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  imem_loader #(.DEPTH(1024), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit gaps = 1'b0;
  logic [15:0] img[8];
  int img_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int w;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] n, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < img_n; i++) begin
      send_byte(img[i][15:8]);
      send_byte(img[i][7:0]);
      x = x ^ img[i][15:8] ^ img[i][7:0];
    end
`ifdef LOADER_CSUM_EN
    send_byte(x ^ flip);
`else
    x = flip;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_writes(input string tag, input int n);
    #1;
    chk({tag, "_count"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, {16'd0, wr_addr[i]}, i);
      chk({tag, "_data"}, {16'd0, wr_data[i]}, {16'd0, img[i]});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_waddr"}, {16'd0, imem_waddr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_hold", {31'd0, cpu_hold}, 32'd1);

    // start together with a valid byte in IDLE: the byte must not be consumed
    start = 1'b1; in_valid = 1'b1; in_byte = 8'hEE;
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("lenhi_ready", {31'd0, in_ready}, 32'd1);
    chk("lenhi_hold", {31'd0, cpu_hold}, 32'd1);

    // N=3 back-to-back
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h0001; img_n = 3;
    clear_log();
    send_image(16'd3, 8'h00);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_hold", {31'd0, cpu_hold}, 32'd0);
    chk("b2b_ready", {31'd0, in_ready}, 32'd0);
`ifndef LOADER_CSUM_EN
    chk("b2b_last_we", {31'd0, imem_we}, 32'd1);
    chk("b2b_last_addr", {16'd0, imem_waddr}, 32'd2);
    chk("b2b_last_data", {16'd0, imem_wdata}, 32'h0001);
`endif
    chk_writes("b2b", 3);
    if (wr_cyc.size() == 3) begin
      chk("b2b_gap01", wr_cyc[1] - wr_cyc[0], 32'd2);
      chk("b2b_gap12", wr_cyc[2] - wr_cyc[1], 32'd2);
    end

    // start in DONE raises cpu_hold; reload with random in_valid gaps
    pulse_start();
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    gaps = 1'b1;
    clear_log();
    send_image(16'd3, 8'h00);
    gaps = 1'b0;
    chk("gap_done", {31'd0, done}, 32'd1);
    chk_writes("gap", 3);

    // N=0
    pulse_start();
    img_n = 0;
    clear_log();
    send_image(16'd0, 8'h00);
    chk("n0_done", {31'd0, done}, 32'd1);
    chk_writes("n0", 0);

    // N=DEPTH+1 aborts, then a valid stream recovers
    pulse_start();
    clear_log();
    send_byte(8'h04);
    send_byte(8'h01);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_hold", {31'd0, cpu_hold}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd0);
    chk("ovf_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("ovf_no_we", wr_addr.size(), 32'd0);
    pulse_start();
    chk("ovf_restart_err", {31'd0, err}, 32'd0);
    img[0] = 16'hBEEF; img_n = 1;
    clear_log();
    send_image(16'd1, 8'h00);
    chk("rec_done", {31'd0, done}, 32'd1);
    chk_writes("rec", 1);

`ifdef LOADER_CSUM_EN
    // hand-computed checksum 0x12^0x34^0x56^0x78 = 0x08
    img[0] = 16'h1234; img[1] = 16'h5678; img_n = 2;
    pulse_start();
    clear_log();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h08);
    chk("csum_ok_done", {31'd0, done}, 32'd1);
    chk("csum_ok_hold", {31'd0, cpu_hold}, 32'd0);
    chk_writes("csum_ok", 2);
    pulse_start();
    clear_log();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    chk("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("csum_bad_done", {31'd0, done}, 32'd0);
    chk_writes("csum_bad", 2);
`endif

    // reset after 3 bytes of a 4-word load
    pulse_start();
    clear_log();
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h12);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_no_we", wr_addr.size(), 32'd0);
    pulse_start();
    img[0] = 16'hCAFE; img[1] = 16'hF00D; img_n = 2;
    clear_log();
    send_image(16'd2, 8'h00);
    chk("reload_done", {31'd0, done}, 32'd1);
    chk_writes("reload", 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory before the CPU fetches from it. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes each word into consecutive imem addresses starting at 0, and holds the CPU in reset until the image has loaded cleanly.

## Interface
Parameters:
- DEPTH, 1024: imem capacity in words; a word count above this is an error.
- AW, 16: imem write address width; matches the PC width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- in_valid  in  1  byte-stream valid.
- in_byte  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte transfers on a cycle where in_valid and in_ready are both high.
- imem_we  out  1  imem write strobe.
- imem_waddr  out  AW  imem write address.
- imem_wdata  out  16  imem write data.
- cpu_hold  out  1  drives the CPU/PC reset; high means the CPU is held.
- done  out  1  image loaded and accepted.
- err  out  1  load aborted.

## Operation
- Stream format: LEN_HI, LEN_LO (word count N, 16 bit), then N words as HI byte then LO byte.
- With the checksum feature enabled, one checksum byte follows the words.
- State machine:
  - IDLE: start -> LEN_HI.
  - LEN_HI: byte accepted -> LEN_LO.
  - LEN_LO: byte accepted; N=0 -> CSUM or DONE; N>DEPTH -> ERR; otherwise -> DATA_HI.
  - DATA_HI: byte accepted -> DATA_LO.
  - DATA_LO: byte accepted; last word -> CSUM or DONE; otherwise -> DATA_HI.
  - CSUM: byte accepted; match -> DONE, mismatch -> ERR.
  - DONE, ERR: start -> LEN_HI.
- in_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
- start is ignored in every other state, so it does not restart a load in progress.
- Word counter: AW+1 bits, cleared on entry to LEN_HI. The write address equals the counter value before its increment.
- Words land at addresses 0..N-1. Locations N and above are left untouched.
- cpu_hold is low only in DONE.
- done is high only in DONE.
- err is high only in ERR.
- A start in DONE raises cpu_hold again on the next cycle.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE, counter=0.
- Throughput: one byte per cycle, so the peak is one imem write every 2 cycles.
- imem_we is registered. It is high for exactly the one cycle after each DATA_LO transfer, with the address and data valid in that same cycle.
- The last write and the move to DONE happen in the same cycle.
- done and cpu_hold change in the cycle after the final byte (the LO byte, or the checksum byte when enabled).
- If in_valid is low while in_ready is high, the FSM stalls with no timeout.
- Reset mid-load returns to IDLE immediately. A write already strobed completes, no further writes occur, and cpu_hold=1.
- If start and in_valid are asserted in the same cycle in IDLE, only start takes effect. The byte is not consumed because in_ready is 0.

## Configuration
- LOADER_CSUM_EN defined:
  - A running XOR of all data bytes (length bytes excluded) is cleared on entry to LEN_HI.
  - CSUM state expects that XOR; a mismatch sends the FSM to ERR, with cpu_hold still high.
  - Words already written stay in imem.
- LOADER_CSUM_EN undefined:
  - No CSUM state and no XOR register.
  - The stream ends after the last LO byte.

## Structure
- Shared package `loader_pkg`:
  - state encoding typedef (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR);
  - the DEPTH default.
- No sub-module: a single FSM plus datapath registers.
- The imem is expected to gain a write port (we, waddr, wdata) that connects directly to this block.

## Test plan
- Load N=3, words 0x1234, 0xABCD, 0x0001, bytes back-to-back -> imem_we pulses at addresses 0, 1 and 2 with matching data on alternate cycles; done=1 and cpu_hold=0 the cycle after the last byte.
- Same stream with in_valid toggled randomly -> identical writes, and no byte is lost or duplicated.
- N=0 -> no imem_we; DONE follows LEN_LO directly, or after the checksum byte 0x00 with LOADER_CSUM_EN.
- N=DEPTH+1 (0x0401) -> err=1 after LEN_LO, no writes, cpu_hold=1; a subsequent start followed by a valid stream reaches DONE.
- LOADER_CSUM_EN with words 0x1234, 0x5678: checksum byte 0x08 -> DONE; checksum byte 0x09 -> ERR with cpu_hold=1.
- Reset pulsed after 3 bytes of a 4-word load -> all outputs return to their reset values at once; start is pulsed in IDLE before the next stream, which reloads from address 0.
